combat_referee: RTL and testbench

Match-level controller and hit arbiter sitting between the two player instances and the renderer. Each cycle (one game frame) it checks the active attack boxes against the opponent hurtboxes and resolves simultaneous hits. It issues one-cycle hit pulses to each player, tracks health and round wins, and sequences intro/fight/KO/match-over phases, including a hold signal that freezes both players.

---
 rtl/combat_referee_pkg.sv | 74 +++++++
 rtl/combat_referee_box_overlap.sv | 20 ++
 rtl/combat_referee.sv | 198 +++++++++++++++++++
 tb/tb_combat_referee.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/combat_referee_pkg.sv
// Shared definitions for the combat referee: widths, match timing, player
// state codes, hit flag / winner encodings, round phases and box packing.
package combat_referee_pkg;

    // Widths
    localparam int unsigned STATE_W     = 4;
    localparam int unsigned HP_W        = 3;
    localparam int unsigned ROUND_W     = 2;
    localparam int unsigned TIMER_W     = 12;
    localparam int unsigned FLAG_W      = 2;
    localparam int unsigned WIN_W       = 2;
    localparam int unsigned COORD_W     = 10;
    localparam int unsigned BOX_W       = 4 * COORD_W;
    localparam int unsigned FRAME_CNT_W = 7;

    // Match timing and rules
    localparam int unsigned HP_INIT       = 5;
    localparam int unsigned ROUNDS_TO_WIN = 2;
    localparam int unsigned INTRO_FRAMES  = 60;
    localparam int unsigned KO_FRAMES     = 90;
    localparam int unsigned ROUND_FRAMES  = 3600;

    // Player FSM state codes (shared with the player instances)
    localparam logic [STATE_W-1:0] PS_IDLE           = 4'd0;
    localparam logic [STATE_W-1:0] PS_MOVE_FWD       = 4'd1;
    localparam logic [STATE_W-1:0] PS_MOVE_BACK      = 4'd2;
    localparam logic [STATE_W-1:0] PS_B_ATTACK_START = 4'd3;
    localparam logic [STATE_W-1:0] PS_B_ATTACK_END   = 4'd4;
    localparam logic [STATE_W-1:0] PS_D_ATTACK_START = 4'd5;
    localparam logic [STATE_W-1:0] PS_D_ATTACK_ACT   = 4'd6;
    localparam logic [STATE_W-1:0] PS_D_ATTACK_END   = 4'd7;
    localparam logic [STATE_W-1:0] PS_JUMP           = 4'd8;
    localparam logic [STATE_W-1:0] PS_HITSTUN        = 4'd9;
    localparam logic [STATE_W-1:0] PS_BLOCKSTUN      = 4'd10;

    // Hit flag encodings
    localparam logic [FLAG_W-1:0] HIT_NONE  = 2'b00;
    localparam logic [FLAG_W-1:0] HIT_BASIC = 2'b01;
    localparam logic [FLAG_W-1:0] HIT_DIR   = 2'b10;

    // Winner encodings
    localparam logic [WIN_W-1:0] WIN_NONE = 2'b00;
    localparam logic [WIN_W-1:0] WIN_P1   = 2'b01;
    localparam logic [WIN_W-1:0] WIN_P2   = 2'b10;
    localparam logic [WIN_W-1:0] WIN_DRAW = 2'b11;

    // Round phases
    typedef enum logic [2:0] {
        R_IDLE       = 3'd0,
        R_INTRO      = 3'd1,
        R_FIGHT      = 3'd2,
        R_KO         = 3'd3,
        R_MATCH_OVER = 3'd4
    } round_state_e;

    // Box packing {x1,x2,y1,y2}
    localparam int unsigned BOX_X1_LSB = 30;
    localparam int unsigned BOX_X2_LSB = 20;
    localparam int unsigned BOX_Y1_LSB = 10;
    localparam int unsigned BOX_Y2_LSB = 0;

    typedef struct packed {
        logic [COORD_W-1:0] x1;
        logic [COORD_W-1:0] x2;
        logic [COORD_W-1:0] y1;
        logic [COORD_W-1:0] y2;
    } box_t;

    // Health decrement that stops at zero
    function automatic logic [HP_W-1:0] hp_sat_dec(input logic [HP_W-1:0] hp);
        return (hp == '0) ? hp : hp - HP_W'(1);
    endfunction

endpackage

// File: rtl/combat_referee_box_overlap.sv
// Inclusive, unsigned axis-aligned overlap test between two packed boxes.
// Ports: a_i, b_i - packed {x1,x2,y1,y2} boxes; overlap_c_o - combinational result.
module combat_referee_box_overlap
    import combat_referee_pkg::*;
(
    input  logic [BOX_W-1:0] a_i,
    input  logic [BOX_W-1:0] b_i,
    output logic             overlap_c_o
);

    box_t a_box;
    box_t b_box;

    assign a_box = a_i;
    assign b_box = b_i;

    assign overlap_c_o = (a_box.x1 <= b_box.x2) && (b_box.x1 <= a_box.x2) &&
                         (a_box.y1 <= b_box.y2) && (b_box.y1 <= a_box.y2);

endmodule

// File: rtl/combat_referee.sv
// Match controller and hit arbiter between the two players and the renderer.
// Inputs: clk, rst (async, active-high), start pulse, player state codes and
// basic/directional/hurt boxes. Outputs (all registered): per-player hit flags,
// health and round wins, round phase, fight timer, player hold and winner.
module combat_referee
    import combat_referee_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [STATE_W-1:0] p1_state,
    input  logic [STATE_W-1:0] p2_state,
    input  logic [BOX_W-1:0]   p1_basic_box,
    input  logic [BOX_W-1:0]   p2_basic_box,
    input  logic [BOX_W-1:0]   p1_dir_box,
    input  logic [BOX_W-1:0]   p2_dir_box,
    input  logic [BOX_W-1:0]   p1_hurt_box,
    input  logic [BOX_W-1:0]   p2_hurt_box,
    output logic [FLAG_W-1:0]  p1_hit_flag,
    output logic [FLAG_W-1:0]  p2_hit_flag,
    output logic [HP_W-1:0]    p1_hp,
    output logic [HP_W-1:0]    p2_hp,
    output logic [ROUND_W-1:0] p1_rounds,
    output logic [ROUND_W-1:0] p2_rounds,
    output logic [2:0]         round_state,
    output logic [TIMER_W-1:0] timer,
    output logic               player_hold,
    output logic [WIN_W-1:0]   winner
);

    round_state_e           round_q, round_d;
    logic [FRAME_CNT_W-1:0] frame_q, frame_d;
    logic [TIMER_W-1:0]     timer_q, timer_d;
    logic [HP_W-1:0]        hp1_q, hp1_d, hp2_q, hp2_d;
    logic [ROUND_W-1:0]     rnd1_q, rnd1_d, rnd2_q, rnd2_d;
    logic [FLAG_W-1:0]      flag1_q, flag1_d, flag2_q, flag2_d;
    logic [WIN_W-1:0]       win_q, win_d;
    logic                   hold_q, hold_d;
    logic                   done1_q, done1_d, done2_q, done2_d;

    logic ov_p1b_c, ov_p1d_c, ov_p2b_c, ov_p2d_c;
    logic [FLAG_W-1:0] atk1_c, atk2_c;
    logic acc1_c, acc2_c;

    // Attack boxes against the opponent's hurtbox
    combat_referee_box_overlap u_ov_p1b (.a_i(p1_basic_box), .b_i(p2_hurt_box), .overlap_c_o(ov_p1b_c));
    combat_referee_box_overlap u_ov_p1d (.a_i(p1_dir_box),   .b_i(p2_hurt_box), .overlap_c_o(ov_p1d_c));
    combat_referee_box_overlap u_ov_p2b (.a_i(p2_basic_box), .b_i(p1_hurt_box), .overlap_c_o(ov_p2b_c));
    combat_referee_box_overlap u_ov_p2d (.a_i(p2_dir_box),   .b_i(p1_hurt_box), .overlap_c_o(ov_p2d_c));

    // Landing attack kind per attacker, then acceptance against a non-stunned defender
    always_comb begin
        atk1_c = HIT_NONE;
        atk2_c = HIT_NONE;
        if (p1_state == PS_B_ATTACK_END && ov_p1b_c)      atk1_c = HIT_BASIC;
        else if (p1_state == PS_D_ATTACK_END && ov_p1d_c) atk1_c = HIT_DIR;
        if (p2_state == PS_B_ATTACK_END && ov_p2b_c)      atk2_c = HIT_BASIC;
        else if (p2_state == PS_D_ATTACK_END && ov_p2d_c) atk2_c = HIT_DIR;
        acc1_c = (round_q == R_FIGHT) && !done1_q && (atk1_c != HIT_NONE) &&
                 (p2_state != PS_HITSTUN) && (p2_state != PS_BLOCKSTUN);
        acc2_c = (round_q == R_FIGHT) && !done2_q && (atk2_c != HIT_NONE) &&
                 (p1_state != PS_HITSTUN) && (p1_state != PS_BLOCKSTUN);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            round_q <= R_IDLE;
            frame_q <= '0;
            timer_q <= '0;
            hp1_q   <= HP_W'(HP_INIT);
            hp2_q   <= HP_W'(HP_INIT);
            rnd1_q  <= '0;
            rnd2_q  <= '0;
            flag1_q <= HIT_NONE;
            flag2_q <= HIT_NONE;
            win_q   <= WIN_NONE;
            hold_q  <= 1'b1;
            done1_q <= 1'b0;
            done2_q <= 1'b0;
        end else begin
            round_q <= round_d;
            frame_q <= frame_d;
            timer_q <= timer_d;
            hp1_q   <= hp1_d;
            hp2_q   <= hp2_d;
            rnd1_q  <= rnd1_d;
            rnd2_q  <= rnd2_d;
            flag1_q <= flag1_d;
            flag2_q <= flag2_d;
            win_q   <= win_d;
            hold_q  <= hold_d;
            done1_q <= done1_d;
            done2_q <= done2_d;
        end
    end

    // Next-state: hit resolution, then round sequencing
    always_comb begin
        round_d = round_q;
        frame_d = frame_q + FRAME_CNT_W'(1);
        timer_d = timer_q;
        hp1_d   = hp1_q;
        hp2_d   = hp2_q;
        rnd1_d  = rnd1_q;
        rnd2_d  = rnd2_q;
        flag1_d = HIT_NONE;
        flag2_d = HIT_NONE;
        win_d   = win_q;
        hold_d  = 1'b1;
        done1_d = done1_q;
        done2_d = done2_q;

        // One hit per attack instance: latch rearms once the attack state is left
        if (p1_state != PS_B_ATTACK_END && p1_state != PS_D_ATTACK_END) done1_d = 1'b0;
        if (p2_state != PS_B_ATTACK_END && p2_state != PS_D_ATTACK_END) done2_d = 1'b0;

        // A backing-off defender blocks: flag still sent, health kept
        if (acc1_c) begin
            done1_d = 1'b1;
            flag2_d = atk1_c;
            if (p2_state != PS_MOVE_BACK) hp2_d = hp_sat_dec(hp2_q);
        end
        if (acc2_c) begin
            done2_d = 1'b1;
            flag1_d = atk2_c;
            if (p1_state != PS_MOVE_BACK) hp1_d = hp_sat_dec(hp1_q);
        end

        unique case (round_q)
            R_IDLE, R_MATCH_OVER: begin
                if (start) begin
                    round_d = R_INTRO;
                    rnd1_d  = '0;
                    rnd2_d  = '0;
                end
            end
            R_INTRO: begin
                if (frame_q == FRAME_CNT_W'(INTRO_FRAMES - 1)) round_d = R_FIGHT;
            end
            R_FIGHT: begin
                timer_d = timer_q - TIMER_W'(1);
                if (hp1_d == '0 || hp2_d == '0) begin
                    // Bit set for each knocked-out side: 10 P2 wins, 01 P1 wins, 11 draw
                    round_d = R_KO;
                    win_d   = {hp1_d == '0, hp2_d == '0};
                end else if (timer_d == '0) begin
                    round_d = R_KO;
                    if (hp1_d > hp2_d)      win_d = WIN_P1;
                    else if (hp2_d > hp1_d) win_d = WIN_P2;
                    else                    win_d = WIN_DRAW;
                end
                if (round_d == R_KO) begin
                    if (win_d == WIN_P1) rnd1_d = rnd1_q + ROUND_W'(1);
                    if (win_d == WIN_P2) rnd2_d = rnd2_q + ROUND_W'(1);
                end
            end
            R_KO: begin
                if (frame_q == FRAME_CNT_W'(KO_FRAMES - 1)) begin
                    if (rnd1_q == ROUND_W'(ROUNDS_TO_WIN) || rnd2_q == ROUND_W'(ROUNDS_TO_WIN))
                        round_d = R_MATCH_OVER;
                    else
                        round_d = R_INTRO;
                end
            end
            default: round_d = R_IDLE;
        endcase

        // Every round starts fresh
        if (round_d == R_INTRO) begin
            hp1_d   = HP_W'(HP_INIT);
            hp2_d   = HP_W'(HP_INIT);
            timer_d = TIMER_W'(ROUND_FRAMES);
            win_d   = WIN_NONE;
        end

        // Flags only leave the block while fighting continues
        if (round_d != R_FIGHT) begin
            flag1_d = HIT_NONE;
            flag2_d = HIT_NONE;
        end

        if (round_d != round_q) frame_d = '0;
        hold_d = !(round_d == R_FIGHT || round_d == R_KO);
    end

    assign round_state = round_q;
    assign p1_hit_flag = flag1_q;
    assign p2_hit_flag = flag2_q;
    assign p1_hp       = hp1_q;
    assign p2_hp       = hp2_q;
    assign p1_rounds   = rnd1_q;
    assign p2_rounds   = rnd2_q;
    assign timer       = timer_q;
    assign player_hold = hold_q;
    assign winner      = win_q;

endmodule

// File: tb/tb_combat_referee.sv
// Self-checking bench for combat_referee: directed match scenarios plus random
// play, every output compared each frame against a behavioural match model.
module tb_combat_referee;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  p1_state, p2_state;
    logic [39:0] p1_basic_box, p2_basic_box, p1_dir_box, p2_dir_box, p1_hurt_box, p2_hurt_box;
    logic [1:0]  p1_hit_flag, p2_hit_flag;
    logic [2:0]  p1_hp, p2_hp;
    logic [1:0]  p1_rounds, p2_rounds;
    logic [2:0]  round_state;
    logic [11:0] timer;
    logic        player_hold;
    logic [1:0]  winner;

    always #5 clk = ~clk;

    combat_referee dut (
        .clk(clk), .rst(rst), .start(start),
        .p1_state(p1_state), .p2_state(p2_state),
        .p1_basic_box(p1_basic_box), .p2_basic_box(p2_basic_box),
        .p1_dir_box(p1_dir_box), .p2_dir_box(p2_dir_box),
        .p1_hurt_box(p1_hurt_box), .p2_hurt_box(p2_hurt_box),
        .p1_hit_flag(p1_hit_flag), .p2_hit_flag(p2_hit_flag),
        .p1_hp(p1_hp), .p2_hp(p2_hp),
        .p1_rounds(p1_rounds), .p2_rounds(p2_rounds),
        .round_state(round_state), .timer(timer),
        .player_hold(player_hold), .winner(winner)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    // Match model: phase 0 idle, 1 intro, 2 fight, 3 KO, 4 match over
    int m_phase, m_left, m_timer, m_winner;
    int m_hp[2], m_rounds[2], m_flag[2];
    bit m_done[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic logic [39:0] mk_box(input int x1, input int x2, input int y1, input int y2);
        return {10'(x1), 10'(x2), 10'(y1), 10'(y2)};
    endfunction

    function automatic bit overlaps(input logic [39:0] a, input logic [39:0] b);
        int ax1 = int'(a[39:30]); int ax2 = int'(a[29:20]);
        int ay1 = int'(a[19:10]); int ay2 = int'(a[9:0]);
        int bx1 = int'(b[39:30]); int bx2 = int'(b[29:20]);
        int by1 = int'(b[19:10]); int by2 = int'(b[9:0]);
        return (ax1 <= bx2) && (bx1 <= ax2) && (ay1 <= by2) && (by1 <= ay2);
    endfunction

    function automatic int hit_kind(input int st, input logic [39:0] basic,
                                    input logic [39:0] dir, input logic [39:0] hurt);
        if (st == 4 && overlaps(basic, hurt)) return 1;
        if (st == 7 && overlaps(dir, hurt))   return 2;
        return 0;
    endfunction

    function automatic logic [39:0] rand_box();
        int x1 = $urandom_range(0, 400);
        int y1 = $urandom_range(0, 400);
        int x2 = x1 + $urandom_range(0, 250);
        int y2 = y1 + $urandom_range(0, 250);
        if ($urandom_range(0, 9) == 0) x2 = $urandom_range(0, 1023);
        return mk_box(x1, x2, y1, y2);
    endfunction

    function automatic logic [3:0] rand_state();
        int r = $urandom_range(0, 9);
        case (r)
            0, 1:    return 4'd0;
            2:       return 4'd2;
            3, 4:    return 4'd4;
            5, 6:    return 4'd7;
            7:       return 4'd9;
            8:       return 4'd10;
            default: return 4'($urandom_range(0, 15));
        endcase
    endfunction

    task automatic model_reset();
        m_phase = 0; m_left = 0; m_timer = 0; m_winner = 0;
        for (int i = 0; i < 2; i++) begin
            m_hp[i] = 5; m_rounds[i] = 0; m_flag[i] = 0; m_done[i] = 0;
        end
    endtask

    task automatic enter_intro();
        m_phase = 1; m_left = 60; m_timer = 3600; m_winner = 0;
        m_hp[0] = 5; m_hp[1] = 5;
    endtask

    task automatic model_step();
        int st[2], kind[2], nf[2], w;
        bit acc[2];
        st[0] = int'(p1_state);
        st[1] = int'(p2_state);
        kind[0] = hit_kind(st[0], p1_basic_box, p1_dir_box, p2_hurt_box);
        kind[1] = hit_kind(st[1], p2_basic_box, p2_dir_box, p1_hurt_box);
        nf[0] = 0; nf[1] = 0;
        for (int a = 0; a < 2; a++)
            acc[a] = (m_phase == 2) && !m_done[a] && kind[a] != 0 && st[1-a] != 9 && st[1-a] != 10;
        for (int a = 0; a < 2; a++) begin
            if (acc[a]) m_done[a] = 1;
            else if (st[a] != 4 && st[a] != 7) m_done[a] = 0;
        end
        case (m_phase)
            0, 4: if (start) begin
                m_rounds[0] = 0; m_rounds[1] = 0;
                enter_intro();
            end
            1: begin
                m_left--;
                if (m_left == 0) m_phase = 2;
            end
            2: begin
                for (int a = 0; a < 2; a++) if (acc[a]) begin
                    nf[1-a] = kind[a];
                    if (st[1-a] != 2 && m_hp[1-a] > 0) m_hp[1-a]--;
                end
                m_timer--;
                w = 0;
                if (m_hp[0] == 0 || m_hp[1] == 0)
                    w = (m_hp[0] > 0) ? 1 : (m_hp[1] > 0) ? 2 : 3;
                else if (m_timer == 0)
                    w = (m_hp[0] > m_hp[1]) ? 1 : (m_hp[1] > m_hp[0]) ? 2 : 3;
                if (w != 0) begin
                    m_phase = 3; m_left = 90; m_winner = w;
                    if (w == 1) m_rounds[0]++;
                    if (w == 2) m_rounds[1]++;
                    nf[0] = 0; nf[1] = 0;
                end
            end
            3: begin
                m_left--;
                if (m_left == 0) begin
                    if (m_rounds[0] == 2 || m_rounds[1] == 2) m_phase = 4;
                    else enter_intro();
                end
            end
            default: m_phase = 0;
        endcase
        m_flag[0] = nf[0];
        m_flag[1] = nf[1];
    endtask

    task automatic compare_all();
        chk("round_state", 32'(round_state), m_phase);
        chk("p1_hp", 32'(p1_hp), m_hp[0]);
        chk("p2_hp", 32'(p2_hp), m_hp[1]);
        chk("p1_hit_flag", 32'(p1_hit_flag), m_flag[0]);
        chk("p2_hit_flag", 32'(p2_hit_flag), m_flag[1]);
        chk("p1_rounds", 32'(p1_rounds), m_rounds[0]);
        chk("p2_rounds", 32'(p2_rounds), m_rounds[1]);
        chk("timer", 32'(timer), m_timer);
        chk("player_hold", 32'(player_hold), (m_phase == 2 || m_phase == 3) ? 0 : 1);
        chk("winner", 32'(winner), m_winner);
    endtask

    // One frame: model follows the same edge, outputs sampled just after it
    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic run_to_phase(input int ph, input int budget);
        for (int i = 0; i < budget && m_phase != ph; i++) tick();
    endtask

    task automatic hit_until_ko();
        for (int i = 0; i < 20 && m_phase == 2; i++) begin
            p1_state = 4'd4; tick();
            p1_state = 4'd0; tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; start = 1'b0;
        p1_state = '0; p2_state = '0;
        p1_basic_box = mk_box(130, 213, 194, 227);
        p2_hurt_box  = mk_box(200, 253, 170, 320);
        p1_hurt_box  = mk_box(100, 200, 150, 250);
        p2_dir_box   = mk_box(150, 180, 200, 220);
        p2_basic_box = mk_box(900, 950, 900, 950);
        p1_dir_box   = mk_box(900, 950, 900, 950);
        #1 rst = 1'b1;
        #1 model_reset();
        compare_all();
        run(3);
        rst = 1'b0;
        run(2);

        // Match start and intro length
        start = 1'b1; tick(); start = 1'b0;
        chk("intro_entry", 32'(round_state), 1);
        run(59);
        chk("intro_hold", 32'(player_hold), 1);
        tick();
        chk("fight_entry", 32'(round_state), 2);
        chk("fight_hold", 32'(player_hold), 0);
        chk("fight_timer", 32'(timer), 3600);

        // Basic hit, single pulse while attack held
        p1_state = 4'd4; tick();
        chk("basic_flag", 32'(p2_hit_flag), 1);
        chk("basic_hp", 32'(p2_hp), 4);
        tick();
        chk("basic_one_pulse", 32'(p2_hit_flag), 0);
        run(3);
        p1_state = 4'd0; tick();

        // Blocked hit
        p2_state = 4'd2; p1_state = 4'd4; tick();
        chk("block_flag", 32'(p2_hit_flag), 1);
        chk("block_hp", 32'(p2_hp), 4);
        run(2);
        p1_state = 4'd0; p2_state = 4'd0; tick();

        // Hitstun defender: deferred, not consumed
        p2_state = 4'd9; p1_state = 4'd4; run(3);
        chk("stun_no_flag", 32'(p2_hit_flag), 0);
        p2_state = 4'd0; tick();
        chk("stun_late_flag", 32'(p2_hit_flag), 1);
        chk("stun_late_hp", 32'(p2_hp), 3);
        p1_state = 4'd0; tick();

        // Trade
        p1_state = 4'd4; p2_state = 4'd7; tick();
        chk("trade_p1_flag", 32'(p1_hit_flag), 2);
        chk("trade_p2_flag", 32'(p2_hit_flag), 1);
        chk("trade_p1_hp", 32'(p1_hp), 4);
        chk("trade_p2_hp", 32'(p2_hp), 2);
        p1_state = 4'd0; p2_state = 4'd0; tick();

        // KO, first round to P1
        hit_until_ko();
        chk("ko_state", 32'(round_state), 3);
        chk("ko_winner", 32'(winner), 1);
        chk("ko_rounds", 32'(p1_rounds), 1);
        run(88);
        chk("ko_length", 32'(round_state), 3);
        tick();
        chk("ko_to_intro", 32'(round_state), 1);

        // Second round to P1 ends the match
        run(60);
        hit_until_ko();
        chk("match_rounds", 32'(p1_rounds), 2);
        run_to_phase(4, 200);
        chk("match_over", 32'(round_state), 4);
        chk("match_hold", 32'(player_hold), 1);
        chk("match_winner", 32'(winner), 1);
        start = 1'b1; tick(); start = 1'b0;
        chk("restart_state", 32'(round_state), 1);
        chk("restart_rounds", 32'(p1_rounds), 0);

        // Timeout with equal health is a draw
        run(60);
        repeat (2) begin
            p1_state = 4'd4; p2_state = 4'd7; tick();
            p1_state = 4'd0; p2_state = 4'd0; tick();
        end
        run_to_phase(3, 4000);
        chk("timeout_state", 32'(round_state), 3);
        chk("timeout_winner", 32'(winner), 3);
        chk("timeout_rounds", 32'(p1_rounds + p2_rounds), 0);

        // Asynchronous reset mid-fight drops a pending flag
        run_to_phase(2, 300);
        p1_state = 4'd4; tick();
        rst = 1'b1;
        #1 model_reset();
        compare_all();
        chk("rst_flag", 32'(p2_hit_flag), 0);
        chk("rst_state", 32'(round_state), 0);
        run(2);
        rst = 1'b0; p1_state = 4'd0;
        run(2);

        // Random play
        for (int i = 0; i < 8000; i++) begin
            start    = ($urandom_range(0, 99) == 0);
            p1_state = rand_state();
            p2_state = rand_state();
            if ($urandom_range(0, 3) == 0) begin
                p1_basic_box = rand_box(); p2_basic_box = rand_box();
                p1_dir_box   = rand_box(); p2_dir_box   = rand_box();
                p1_hurt_box  = rand_box(); p2_hurt_box  = rand_box();
            end
            rst = ($urandom_range(0, 2999) == 0);
            tick();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
